// File: rtl/ctrl_types.sv
// Shared types and constants for the pipeline control slice.
package ctrl_types;

    localparam int CNT_W = 32;

    typedef enum logic {
        RUN,
        WAIT_I_DDONE
    } pipe_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds ID.
module hazard_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    output logic       load_use
);

    // x0 never carries a real dependency, so a load to it cannot cause a hazard
    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory stalls, branch flushes, load-use bubbles
// and stall/flush performance counters.
module pipeline_ctrl
    import ctrl_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ex_br_taken,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             ifid_rst,
    output logic             idex_load,
    output logic             idex_rst,
    output logic             exmem_load,
    output logic             exmem_rst,
    output logic             memwb_load,
    output logic             memwb_rst,
    output logic             dmem_mask,
    output logic             rdata_hold_load,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_e state, next_state;
    logic dmem_access, i_stall, d_stall, mem_stall, load_use, flush;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .load_use      (load_use)
    );

    // Once the data side finished while fetch is still waiting, mask the data
    // access so it is not re-issued and its early response is not waited on again.
    assign dmem_access     = dmem_read | dmem_write;
    assign dmem_mask       = rst & (state == WAIT_I_DDONE);
    assign i_stall         = imem_read & ~imem_resp;
    assign d_stall         = dmem_access & ~dmem_resp & ~dmem_mask;
    assign mem_stall       = i_stall | d_stall | ((state == WAIT_I_DDONE) & ~imem_resp);
    assign rdata_hold_load = rst & (state == RUN) & i_stall & dmem_resp & dmem_access;
    assign flush           = ~mem_stall & ex_br_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:          if (i_stall && dmem_resp && dmem_access) next_state = WAIT_I_DDONE;
            WAIT_I_DDONE: if (imem_resp) next_state = RUN;
            default:      next_state = RUN;
        endcase
    end

    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_rst   = 1'b1;
        idex_rst   = 1'b1;
        exmem_rst  = 1'b1;
        memwb_rst  = 1'b1;
        if (rst) begin
            ifid_rst  = 1'b0;
            idex_rst  = 1'b0;
            exmem_rst = 1'b0;
            memwb_rst = 1'b0;
            if (mem_stall) begin
                pc_load = 1'b0;
            end else if (ex_br_taken) begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                idex_load  = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
                ifid_rst   = 1'b1;
                idex_rst   = 1'b1;
            end else if (load_use) begin
                idex_load  = 1'b1;
                idex_rst   = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
            end else begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                idex_load  = 1'b1;
                exmem_load = 1'b1;
                memwb_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_load) stall_cnt <= stall_cnt + 1'b1;
            if (flush)    flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic        idex_mem_read, ex_br_taken;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        pc_load, ifid_load, ifid_rst, idex_load, idex_rst;
    logic        exmem_load, exmem_rst, memwb_load, memwb_rst;
    logic        dmem_mask, rdata_hold_load;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // {pc, ifid, idex, exmem, memwb loads, ifid, idex, exmem, memwb clears}
    localparam logic [8:0] CTL_RUN   = 9'b11111_0000;
    localparam logic [8:0] CTL_STALL = 9'b00000_0000;
    localparam logic [8:0] CTL_FLUSH = 9'b11111_1100;
    localparam logic [8:0] CTL_LDUSE = 9'b00111_0100;
    localparam logic [8:0] CTL_RESET = 9'b00000_1111;

    logic [8:0] ctl;
    assign ctl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                  ifid_rst, idex_rst, exmem_rst, memwb_rst};

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .imem_read       (imem_read),
        .imem_resp       (imem_resp),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_resp       (dmem_resp),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .ex_br_taken     (ex_br_taken),
        .pc_load         (pc_load),
        .ifid_load       (ifid_load),
        .ifid_rst        (ifid_rst),
        .idex_load       (idex_load),
        .idex_rst        (idex_rst),
        .exmem_load      (exmem_load),
        .exmem_rst       (exmem_rst),
        .memwb_load      (memwb_load),
        .memwb_rst       (memwb_rst),
        .dmem_mask       (dmem_mask),
        .rdata_hold_load (rdata_hold_load),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a new input vector mid-cycle and let the combinational outputs settle
    task automatic applyStimulus(input logic ir, input logic irsp, input logic dr,
                                 input logic dw, input logic drsp, input logic br,
                                 input logic mr, input logic [4:0] rd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        imem_read = ir; imem_resp = irsp; dmem_read = dr; dmem_write = dw;
        dmem_resp = drsp; ex_br_taken = br; idex_mem_read = mr;
        idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
        ex_br_taken = 0; idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        #3;
        checkOutput("reset_ctl", {23'd0, ctl}, {23'd0, CTL_RESET});
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset_flush_cnt", flush_cnt, 32'd0);
        checkOutput("reset_mask", {31'd0, dmem_mask}, 32'd0);
        checkOutput("reset_rhl", {31'd0, rdata_hold_load}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("idle_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
        tick();
        checkOutput("idle_stall_cnt", stall_cnt, 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5);
        checkOutput("lduse_rs2_ctl", {23'd0, ctl}, {23'd0, CTL_LDUSE});
        tick();
        checkOutput("lduse_rs2_stall_cnt", stall_cnt, 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
        checkOutput("lduse_rs1_ctl", {23'd0, ctl}, {23'd0, CTL_LDUSE});
        tick();
        checkOutput("lduse_rs1_stall_cnt", stall_cnt, 32'd2);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd7);
        checkOutput("rd_zero_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
        tick();
        checkOutput("rd_zero_stall_cnt", stall_cnt, 32'd2);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5);
        checkOutput("no_load_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});

        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("flush_ctl", {23'd0, ctl}, {23'd0, CTL_FLUSH});
        tick();
        checkOutput("flush_cnt_1", flush_cnt, 32'd1);
        checkOutput("flush_stall_cnt", stall_cnt, 32'd2);

        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd9, 5'd9, 5'd0);
        checkOutput("flush_vs_lduse_ctl", {23'd0, ctl}, {23'd0, CTL_FLUSH});
        tick();
        checkOutput("flush_vs_lduse_flush_cnt", flush_cnt, 32'd2);
        checkOutput("flush_vs_lduse_stall_cnt", stall_cnt, 32'd2);

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("stall_vs_br_ctl", {23'd0, ctl}, {23'd0, CTL_STALL});
        tick();
        checkOutput("stall_vs_br_flush_cnt", flush_cnt, 32'd2);
        checkOutput("stall_vs_br_stall_cnt", stall_cnt, 32'd3);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("deferred_br_ctl", {23'd0, ctl}, {23'd0, CTL_FLUSH});
        tick();
        checkOutput("deferred_br_flush_cnt", flush_cnt, 32'd3);

        applyStimulus(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("dstall_ctl", {23'd0, ctl}, {23'd0, CTL_STALL});
        tick();
        checkOutput("dstall_stall_cnt", stall_cnt, 32'd4);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("dresp_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
        tick();

        // Split completion: data answers in cycle 1, fetch answers in cycle 5
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("split_c1_ctl", {23'd0, ctl}, {23'd0, CTL_STALL});
        checkOutput("split_c1_rhl", {31'd0, rdata_hold_load}, 32'd1);
        checkOutput("split_c1_mask", {31'd0, dmem_mask}, 32'd0);
        tick();
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
            checkOutput($sformatf("split_c%0d_ctl", c), {23'd0, ctl}, {23'd0, CTL_STALL});
            checkOutput($sformatf("split_c%0d_rhl", c), {31'd0, rdata_hold_load}, 32'd0);
            checkOutput($sformatf("split_c%0d_mask", c), {31'd0, dmem_mask}, 32'd1);
            tick();
        end
        checkOutput("split_stall_cnt", stall_cnt, 32'd8);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("split_c5_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
        checkOutput("split_c5_mask", {31'd0, dmem_mask}, 32'd1);
        tick();
        checkOutput("split_c5_stall_cnt", stall_cnt, 32'd8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("split_resume_mask", {31'd0, dmem_mask}, 32'd0);
        checkOutput("split_resume_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});

        // Enter WAIT_I_DDONE again, then pull reset asynchronously mid-cycle
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("pre_reset_mask", {31'd0, dmem_mask}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_ctl", {23'd0, ctl}, {23'd0, CTL_RESET});
        checkOutput("async_reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("async_reset_flush_cnt", flush_cnt, 32'd0);
        checkOutput("async_reset_mask", {31'd0, dmem_mask}, 32'd0);
        tick();
        checkOutput("held_reset_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_reset_mask", {31'd0, dmem_mask}, 32'd0);
        checkOutput("post_reset_ctl", {23'd0, ctl}, {23'd0, CTL_STALL});
        checkOutput("post_reset_rhl", {31'd0, rdata_hold_load}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        checkOutput("post_reset_idle_ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
        checkOutput("post_reset_stall_cnt", stall_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
